wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 valid_in  input  1  MEM stage presents a real instruction (0 = bubble).
REQ-005 wb_in  input  2  control group from decode: bit1 = RegWrite, bit0 = MemtoReg.
REQ-006 dest_in  input  5  destination register number.
REQ-007 alu_in  input  32  ALU result carried from MEM.
REQ-008 mem_in  input  32  load data from data memory.
REQ-009 hold  input  1  freeze the stage register; suppress write and retire.
REQ-010 flush  input  1  squash the instruction captured on this edge.
REQ-011 reg_write  output  1  register-file write enable toward decode.
REQ-012 write_register  output  5  register-file write address.
REQ-013 write_data_reg  output  32  register-file write data.
REQ-014 valid_out  output  1  stage register holds a live instruction.
REQ-015 retired  output  CNT_W  count of instructions written back.

Function
REQ-016 On each rising edge with hold=0, the stage register SHALL capture valid_in&~flush, wb_in, dest_in, alu_in and mem_in.
REQ-017 With hold=1 and flush=0, the stage register SHALL keep its contents unchanged.
REQ-018 flush=1 SHALL clear the stored valid bit on that edge regardless of hold; flush has priority over hold.
REQ-019 write_data_reg SHALL be the stored mem value when the stored MemtoReg=1, else the stored alu value; it is combinational from the stage register.
REQ-020 write_register SHALL equal the stored dest.
REQ-021 reg_write SHALL be valid_q & RegWrite_q & ~hold & (dest_q != 0); writes to register 0 are always suppressed.
REQ-022 Latency: inputs present at edge N SHALL drive reg_write/write_data_reg during cycle N+1.
REQ-023 A retire event SHALL occur in each cycle with valid_q=1 and hold=0, whether or not the instruction writes a register.
REQ-024 retired SHALL increment by 1 per retire event and saturate at all-ones; it never wraps.
REQ-025 A held instruction SHALL retire exactly once, in the first cycle after hold deasserts.
REQ-026 Bubbles (valid_in=0) SHALL never assert reg_write or increment retired, whatever wb_in contains.

Reset
REQ-027 While rst=1: valid_q=0, wb_q=0, dest_q=0, data registers 0, retired=0. Outputs: reg_write=0, write_register=0, write_data_reg=0, valid_out=0.
REQ-028 Reset asserted mid-hold SHALL discard the held instruction; no write or retire follows deassertion.

Configuration
REQ-029 Macro WB_BYPASS_EN SHALL add inputs rs_q, rt_q (5 bits each, from decode) and outputs fwd_rs, fwd_rt (1 bit) and fwd_data (32 bits).
REQ-030 With WB_BYPASS_EN defined: fwd_rs = reg_write & (write_register == rs_q); fwd_rt is defined likewise; fwd_data = write_data_reg. This covers the same-cycle write/read hazard in the register map.
REQ-031 Without WB_BYPASS_EN, these ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 The shared package SHALL hold the wb control-bit indices (WB_REGWRITE=1, WB_MEMTOREG=0), the 5-bit register-index type and the zero-register constant; decode uses the same package.
REQ-033 One sub-module, wb_retire_counter (saturating counter with enable), is natural; the rest of the block is flat.

Verification
REQ-034 Capture valid_in=1, wb_in=10, dest_in=5, alu_in=0x0000_1234; next cycle -> reg_write=1, write_register=5, write_data_reg=0x1234, retired=1 after the following edge.
REQ-035 Capture wb_in=11, mem_in=0xDEAD_BEEF, alu_in=0x40, dest_in=8 -> write_data_reg=0xDEADBEEF, reg_write=1.
REQ-036 Capture dest_in=0, wb_in=10 -> reg_write=0, retired still increments by 1; capture valid_in=0, wb_in=11 -> reg_write=0, no increment.
REQ-037 Capture an instruction, then hold=1 for 3 cycles -> reg_write=0 and retired frozen; hold=0 -> exactly one write and +1 retired. Assert hold and flush together -> valid_out=0 next cycle.
REQ-038 With CNT_W=4, retire 17 instructions -> retired=0xF. Assert rst mid-stream -> all outputs 0 immediately, with no clock edge required.
REQ-039 WB_BYPASS_EN: writeback to r9 with rs_q=9, rt_q=3 -> fwd_rs=1, fwd_rt=0, fwd_data=write_data_reg; writeback to r0 with rs_q=0 -> fwd_rs=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared writeback/decode definitions: wb control-bit indices, register-index type,
// and the stage-register layout.
package wb_stage_pkg;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t ZERO_REG = 5'd0;

   typedef struct packed {
      logic        valid;
      logic [1:0]  wb;
      reg_idx_t    dest;
      logic [31:0] alu;
      logic [31:0] mem;
   } wb_stage_reg_t;

endpackage

// File: rtl/wb_stage_retire_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module wb_retire_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (i_en && (r_count != '1))
         r_count <= r_count + CNT_W'(1);
   end

   assign o_count = r_count;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: stage register, register-file write port, retire counter.
// Optional WB_BYPASS_EN adds same-cycle write/read forwarding toward decode.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [1:0]       wb_in,
   input  logic [4:0]       dest_in,
   input  logic [31:0]      alu_in,
   input  logic [31:0]      mem_in,
   input  logic             hold,
   input  logic             flush,
   output logic             reg_write,
   output logic [4:0]       write_register,
   output logic [31:0]      write_data_reg,
   output logic             valid_out,
   output logic [CNT_W-1:0] retired
`ifdef WB_BYPASS_EN
   ,
   input  logic [4:0]       rs_q,
   input  logic [4:0]       rt_q,
   output logic             fwd_rs,
   output logic             fwd_rt,
   output logic [31:0]      fwd_data
`endif
);

   wb_stage_reg_t r_stage;
   logic          w_retire;

   // Flush wins over hold: a held slot can still be squashed, fields kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stage <= '0;
      else if (!hold)
         r_stage <= '{valid: valid_in & ~flush, wb: wb_in, dest: dest_in,
                      alu: alu_in, mem: mem_in};
      else if (flush)
         r_stage.valid <= 1'b0;
   end

   assign write_register = r_stage.dest;
   assign write_data_reg = r_stage.wb[WB_MEMTOREG] ? r_stage.mem : r_stage.alu;
   assign reg_write      = r_stage.valid & r_stage.wb[WB_REGWRITE] & ~hold
                           & (r_stage.dest != ZERO_REG);
   assign valid_out      = r_stage.valid;

   // Retire counts every live instruction leaving the stage, writer or not.
   assign w_retire = r_stage.valid & ~hold;

   wb_retire_counter #(.CNT_W(CNT_W)) u_retire (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_retire),
      .o_count (retired)
   );

`ifdef WB_BYPASS_EN
   assign fwd_rs   = reg_write & (write_register == rs_q);
   assign fwd_rt   = reg_write & (write_register == rt_q);
   assign fwd_data = write_data_reg;
`endif

endmodule
